// File: rtl/aes_inv_shift_rows_stream.sv
// Byte-serial (Inv)ShiftRows: gathers 16 state bytes over a valid/ready stream
// and emits the row-rotated 128-bit state over a second valid/ready stream.
module aes_inv_shift_rows_stream #(
  parameter bit INVERSE = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             byte_first,
  output logic             byte_ready,
  output logic [127:0]     state_out,
  output logic             state_valid,
  input  logic             state_ready,
  output logic             realign_err,
  output logic [CNT_W-1:0] block_count
);

  logic [3:0]        cnt_q, cnt_d;
  logic [14:0][7:0]  blk_q, blk_d;
  logic [127:0]      state_q, state_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  bc_q, bc_d;
  logic              accept;
  logic [15:0][7:0]  full;
  logic [15:0][7:0]  mapped;

  // Packed so that byte k lands at bits [127-8k -: 8]; byte 15 comes straight off the input.
  for (genvar k = 0; k < 15; k++) begin : g_full
    assign full[15-k] = blk_q[k];
  end
  assign full[0] = byte_in;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = INVERSE ? 4*((c - r + 4) % 4) + r : 4*((c + r) % 4) + r;
      assign mapped[15-(4*c+r)] = full[15-SRC];
    end
  end

  assign byte_ready = (cnt_q != 4'd15) || !vld_q || state_ready;
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    state_d = state_q;
    vld_d   = vld_q;
    err_d   = 1'b0;
    bc_d    = bc_q;
    if (vld_q && state_ready) begin
      vld_d = 1'b0;
      bc_d  = bc_q + CNT_W'(1);
    end
    if (accept) begin
      // A mid-block byte_first restarts assembly even at byte 15.
      if (byte_first && cnt_q != 4'd0) begin
        blk_d[0] = byte_in;
        cnt_d    = 4'd1;
        err_d    = 1'b1;
      end else if (cnt_q == 4'd15) begin
        state_d = mapped;
        vld_d   = 1'b1;
        cnt_d   = 4'd0;
      end else begin
        blk_d[cnt_q] = byte_in;
        cnt_d        = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      blk_q   <= '0;
      state_q <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      bc_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      state_q <= state_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      bc_q    <= bc_d;
    end
  end

  assign state_out   = state_q;
  assign state_valid = vld_q;
  assign realign_err = err_q;
  assign block_count = bc_q;

endmodule

// File: tb/tb_aes_inv_shift_rows_stream.sv
// Bench for aes_inv_shift_rows_stream: inverse and forward instances share the
// input stream and are both checked every cycle against a block-level model.
module tb_aes_inv_shift_rows_stream;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   byte_in = '0;
  logic         byte_valid = 1'b0, byte_first = 1'b0, state_ready = 1'b0;
  logic         rdy_i, rdy_f, sv_i, sv_f, err_i, err_f;
  logic [127:0] so_i, so_f;
  logic [15:0]  bc_i, bc_f;

  aes_inv_shift_rows_stream #(.INVERSE(1'b1), .CNT_W(16)) u_inv (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_first(byte_first), .byte_ready(rdy_i), .state_out(so_i),
    .state_valid(sv_i), .state_ready(state_ready), .realign_err(err_i),
    .block_count(bc_i));

  aes_inv_shift_rows_stream #(.INVERSE(1'b0), .CNT_W(16)) u_fwd (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_first(byte_first), .byte_ready(rdy_f), .state_out(so_f),
    .state_valid(sv_f), .state_ready(state_ready), .realign_err(err_f),
    .block_count(bc_f));

  int total = 0, bad = 0;
  int vcnt = 0, ecnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // out[r][c] = in[r][(c-r) mod 4] (inverse) or in[r][(c+r) mod 4] (forward)
  function automatic logic [127:0] mapblk(input logic [7:0] b[16], input bit inv);
    logic [127:0] m;
    int src;
    m = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? 4*((c - r + 4) % 4) + r : 4*((c + r) % 4) + r;
        m[127-8*(4*c+r) -: 8] = b[src];
      end
    return m;
  endfunction

  // Reference: current partial block, one pending output slot, delivered count.
  logic [7:0]   mb[16];
  int           msz, mbc;
  bit           mpend, merr;
  logic [127:0] mi, mf;

  function automatic bit model_ready();
    return !(msz == 15 && mpend && !state_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msz = 0; mbc = 0; mpend = 0; merr = 0; mi = '0; mf = '0;
    end else begin
      bit acc;
      acc  = byte_valid && model_ready();
      merr = 0;
      if (mpend && state_ready) begin
        mpend = 0;
        mbc++;
      end
      if (acc) begin
        if (byte_first && msz != 0) begin
          mb[0] = byte_in; msz = 1; merr = 1;
        end else begin
          mb[msz] = byte_in;
          msz++;
          if (msz == 16) begin
            mi = mapblk(mb, 1'b1);
            mf = mapblk(mb, 1'b0);
            mpend = 1;
            msz = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("byte_ready_inv", rdy_i, model_ready());
      chk("byte_ready_fwd", rdy_f, model_ready());
      chk("state_valid_inv", sv_i, mpend);
      chk("state_valid_fwd", sv_f, mpend);
      if (mpend) begin
        chk("state_out_inv", so_i, mi);
        chk("state_out_fwd", so_f, mf);
      end
      chk("realign_err", {err_i, err_f}, {merr, merr});
      chk("block_count_inv", bc_i, mbc[15:0]);
      chk("block_count_fwd", bc_f, mbc[15:0]);
      if (sv_i) vcnt++;
      if (err_i) ecnt++;
    end
  end

  task automatic send(input logic [7:0] b, input bit f);
    int n;
    bit r;
    n = 0;
    byte_in = b; byte_first = f; byte_valid = 1'b1;
    do begin
      @(negedge clk); r = rdy_i;
      @(posedge clk); n++;
    end while (!r && n < 100);
    #1;
    if (!r) begin
      total++; bad++;
      $display("FAIL send_timeout: byte %h not accepted after %0d cycles", b, n);
    end
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0; byte_first = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    byte_valid = 1'b0; byte_first = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #9 rst_n = 1'b1;
    vcnt = 0; ecnt = 0;
  endtask

  logic [7:0]   arr[16];
  logic [127:0] fwd_res;

  initial begin
    #2; do_reset();
    #1;
    chk("reset_state_out", so_i, 128'h0);
    chk("reset_valid_cnt", {sv_i, err_i, bc_i}, 18'h0);
    chk("reset_ready", rdy_i, 1'b1);

    // Identity pattern through both mappings
    for (int k = 0; k < 16; k++) arr[k] = 8'(k);
    chk("model_pin_inv", mapblk(arr, 1'b1), 128'h000D0A07_04010E0B_0805020F_0C090603);
    chk("model_pin_fwd", mapblk(arr, 1'b0), 128'h00050A0F_04090E03_080D0207_0C01060B);
    state_ready = 1'b1;
    for (int k = 0; k < 16; k++) send(8'(k), k == 0);
    byte_valid = 1'b0;
    chk("ident_inv", so_i, 128'h000D0A07_04010E0B_0805020F_0C090603);
    chk("ident_fwd", so_f, 128'h00050A0F_04090E03_080D0207_0C01060B);
    chk("ident_valid", sv_i, 1'b1);
    fwd_res = so_f;
    idle(1);
    chk("ident_count", bc_i, 16'd1);

    // Round trip: forward result back through the inverse instance
    do_reset();
    for (int k = 0; k < 16; k++) send(fwd_res[127-8*k -: 8], k == 0);
    byte_valid = 1'b0;
    chk("round_trip", so_i, 128'h00010203_04050607_08090A0B_0C0D0E0F);
    idle(2);

    // Backpressure: block A pending holds off byte 15 of block B
    do_reset();
    state_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(8'h10 + 8'(k), k == 0);
    for (int k = 0; k < 15; k++) send(8'h30 + 8'(k), k == 0);
    byte_in = 8'h3F; byte_first = 1'b0; byte_valid = 1'b1;
    for (int k = 0; k < 16; k++) arr[k] = 8'h10 + 8'(k);
    repeat (4) begin
      @(negedge clk);
      chk("bp_ready_low", rdy_i, 1'b0);
      chk("bp_hold_A", so_i, mapblk(arr, 1'b1));
    end
    @(posedge clk); #1 state_ready = 1'b1;
    @(posedge clk); #1 byte_valid = 1'b0;
    for (int k = 0; k < 16; k++) arr[k] = 8'h30 + 8'(k);
    chk("bp_B_out", so_i, mapblk(arr, 1'b1));
    idle(1);
    chk("bp_count", bc_i, 16'd2);

    // Back-to-back blocks with continuous drain
    do_reset();
    state_ready = 1'b1;
    for (int k = 0; k < 48; k++) send(8'($urandom), (k % 16) == 0);
    idle(3);
    chk("drain_valid_cycles", vcnt, 3);
    chk("drain_count", bc_i, 16'd3);

    // Realign: mid-block byte_first drops the partial block
    do_reset();
    for (int k = 0; k < 5; k++) send(8'hE0 + 8'(k), k == 0);
    send(8'hAA, 1'b1);
    for (int k = 1; k < 16; k++) send(8'(k), 1'b0);
    byte_valid = 1'b0;
    arr[0] = 8'hAA;
    for (int k = 1; k < 16; k++) arr[k] = 8'(k);
    chk("realign_out", so_i, mapblk(arr, 1'b1));
    chk("realign_byte0", so_i[127:120], 8'hAA);
    idle(2);
    chk("realign_pulses", ecnt, 1);

    // Asynchronous reset with a pending state and a partial block
    do_reset();
    state_ready = 1'b0;
    for (int k = 0; k < 25; k++) send(8'($urandom), (k % 16) == 0);
    byte_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", so_i, 128'h0);
    chk("async_rst_flags", {sv_i, err_i, bc_i, sv_f}, 19'h0);
    #4 rst_n = 1'b1;
    state_ready = 1'b1;
    for (int k = 0; k < 16; k++) send(8'($urandom), k == 0);
    idle(2);
    chk("post_rst_count", bc_i, 16'd1);

    // Random traffic, realigns and backpressure
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      byte_valid  = ($urandom % 5) != 0;
      byte_in     = 8'($urandom);
      byte_first  = ($urandom % 20) == 0;
      state_ready = ($urandom % 3) != 0;
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
endmodule
